// File: rtl/dram_arbiter_pkg.sv
// ============================================================================
// dram_arbiter_pkg : RAM op encodings and arbiter state type
// Revision 1.0
// ============================================================================
`default_nettype none

package dram_arbiter_pkg;

    // M_WEN op codes: bit 1 = read, bit 0 = IP lane
    localparam logic [1:0] WEN_WR1 = 2'b00;
    localparam logic [1:0] WEN_WR2 = 2'b01;
    localparam logic [1:0] WEN_RD1 = 2'b10;
    localparam logic [1:0] WEN_RD2 = 2'b11;

    typedef enum logic [1:0] {
        ST_RR    = 2'd0,
        ST_LOCK  = 2'd1,
        ST_YIELD = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dram_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : two-requester round-robin pick with last-grant pointer
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic req_cpu_i,
    input  logic req_ip_i,
    output logic gnt_cpu_o,
    output logic gnt_ip_o
);

    // 1 = IP was granted most recently, so CPU wins the next contention
    logic last_ip_q;

    always_comb begin
        gnt_cpu_o = req_cpu_i & (~req_ip_i | last_ip_q);
        gnt_ip_o  = req_ip_i  & (~req_cpu_i | ~last_ip_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ip_q <= 1'b1;
        end else if (gnt_cpu_o) begin
            last_ip_q <= 1'b0;
        end else if (gnt_ip_o) begin
            last_ip_q <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// dram_arbiter : CPU/IP single-port RAM arbiter, optional IP burst lock
// Revision 1.0  -- lock/yield feature enabled by `define DRAM_ARB_LOCK_EN
// ============================================================================
`default_nettype none

module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int AW       = 10,
    parameter int BW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_ADDR,
    input  logic [BW-1:0] C_WDATA,
    output logic          C_GNT,
    output logic          C_RVALID,
    output logic [BW-1:0] C_RDATA,
    input  logic          I_REQ,
    input  logic          I_WE,
    input  logic [AW-1:0] I_ADDR,
    input  logic [BW-1:0] I_WDATA,
    input  logic          I_LOCK,
    output logic          I_GNT,
    output logic          I_RVALID,
    output logic [BW-1:0] I_RDATA,
    output logic          M_CSN,
    output logic [AW-1:0] M_A,
    output logic [1:0]    M_WEN,
    output logic [BW-1:0] M_DI1,
    output logic [BW-1:0] M_DI2,
    input  logic [BW-1:0] M_DOUT1,
    input  logic [BW-1:0] M_DOUT2
);

    logic w_req_cpu, w_req_ip;
    logic w_gnt_cpu, w_gnt_ip;
    logic c_rvalid_q, i_rvalid_q;

`ifdef DRAM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          w_lock_full;

    assign w_lock_full = (cnt_q >= CW'(LOCK_MAX));

    // State masks the requests; the round-robin picker then sees one requester
    always_comb begin
        w_req_cpu = C_REQ & ~RST;
        w_req_ip  = I_REQ & ~RST;
        case (state_q)
            ST_LOCK: begin
                w_req_cpu = 1'b0;
                if (w_lock_full && C_REQ) begin
                    w_req_ip = 1'b0;
                end
            end
            ST_YIELD: w_req_ip = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RR: begin
                    if (w_gnt_ip && I_LOCK) begin
                        state_q <= ST_LOCK;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_LOCK: begin
                    if (!I_LOCK || !I_REQ) begin
                        state_q <= ST_RR;
                        cnt_q   <= '0;
                    end else begin
                        if (w_gnt_ip && !w_lock_full) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                        if (C_REQ && (w_lock_full ||
                                      (w_gnt_ip && cnt_q == CW'(LOCK_MAX - 1)))) begin
                            state_q <= ST_YIELD;
                        end
                    end
                end
                ST_YIELD: begin
                    state_q <= ST_RR;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_RR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
`else
    // Without the lock feature the arbiter is permanently in plain round-robin
    logic w_unused_lock;
    assign w_unused_lock = I_LOCK;

    always_comb begin
        w_req_cpu = C_REQ & ~RST;
        w_req_ip  = I_REQ & ~RST;
    end
`endif

    rr_pick2 u_rr_pick2 (
        .clk       (CLK),
        .rst       (RST),
        .req_cpu_i (w_req_cpu),
        .req_ip_i  (w_req_ip),
        .gnt_cpu_o (w_gnt_cpu),
        .gnt_ip_o  (w_gnt_ip)
    );

    always_comb begin
        C_GNT = w_gnt_cpu;
        I_GNT = w_gnt_ip;
        M_CSN = w_gnt_cpu | w_gnt_ip;
        M_A   = '0;
        M_WEN = WEN_RD1;
        if (w_gnt_cpu) begin
            M_A   = C_ADDR;
            M_WEN = C_WE ? WEN_WR1 : WEN_RD1;
        end else if (w_gnt_ip) begin
            M_A   = I_ADDR;
            M_WEN = I_WE ? WEN_WR2 : WEN_RD2;
        end
    end

    assign M_DI1   = C_WDATA;
    assign M_DI2   = I_WDATA;
    assign C_RDATA = M_DOUT1;
    assign I_RDATA = M_DOUT2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_rvalid_q <= 1'b0;
            i_rvalid_q <= 1'b0;
        end else begin
            c_rvalid_q <= w_gnt_cpu & ~C_WE;
            i_rvalid_q <= w_gnt_ip & ~I_WE;
        end
    end

    // Masking with RST kills a response whose read was granted just before reset
    assign C_RVALID = c_rvalid_q & ~RST;
    assign I_RVALID = i_rvalid_q & ~RST;

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
// tb_dram_arbiter : directed self-checking bench for dram_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dram_arbiter;

    localparam int AW = 10;
    localparam int BW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          C_REQ, C_WE, I_REQ, I_WE, I_LOCK;
    logic [AW-1:0] C_ADDR, I_ADDR;
    logic [BW-1:0] C_WDATA, I_WDATA;
    logic          C_GNT, C_RVALID, I_GNT, I_RVALID, M_CSN;
    logic [BW-1:0] C_RDATA, I_RDATA, M_DI1, M_DI2;
    logic [BW-1:0] M_DOUT1, M_DOUT2;
    logic [AW-1:0] M_A;
    logic [1:0]    M_WEN;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] mem [0:(1<<AW)-1];

    always #5 CLK = ~CLK;

    dram_arbiter #(.AW(AW), .BW(BW), .LOCK_MAX(16)) dut (
        .CLK(CLK), .RST(RST),
        .C_REQ(C_REQ), .C_WE(C_WE), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
        .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RDATA(C_RDATA),
        .I_REQ(I_REQ), .I_WE(I_WE), .I_ADDR(I_ADDR), .I_WDATA(I_WDATA),
        .I_LOCK(I_LOCK), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .M_CSN(M_CSN), .M_A(M_A), .M_WEN(M_WEN), .M_DI1(M_DI1), .M_DI2(M_DI2),
        .M_DOUT1(M_DOUT1), .M_DOUT2(M_DOUT2)
    );

    // Single-port RAM with registered read lanes
    always @(posedge CLK) begin
        if (M_CSN) begin
            case (M_WEN)
                2'b00: mem[M_A] <= M_DI1;
                2'b01: mem[M_A] <= M_DI2;
                2'b10: M_DOUT1  <= mem[M_A];
                default: M_DOUT2 <= mem[M_A];
            endcase
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; C_REQ = 1'b0; I_REQ = 1'b0; I_LOCK = 1'b0;
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; C_REQ = 1'b1; I_REQ = 1'b1; C_WE = 1'b0; I_WE = 1'b0;
        I_LOCK = 1'b0; C_ADDR = 10'd1; I_ADDR = 10'd2;
        C_WDATA = 32'h1111_2222; I_WDATA = 32'h3333_4444;
        next_cycle();
        next_cycle();
        #2;
        total++; if (C_GNT !== 1'b0) begin bad++; $display("FAIL rst_cgnt got=%b exp=0", C_GNT); end
        total++; if (I_GNT !== 1'b0) begin bad++; $display("FAIL rst_ignt got=%b exp=0", I_GNT); end
        total++; if (M_CSN !== 1'b0) begin bad++; $display("FAIL rst_csn got=%b exp=0", M_CSN); end
        total++; if (C_RVALID !== 1'b0 || I_RVALID !== 1'b0) begin
            bad++; $display("FAIL rst_rvalid got=%b%b exp=00", C_RVALID, I_RVALID); end
        next_cycle();
        RST = 1'b0; C_REQ = 1'b0; I_REQ = 1'b0;
        #2;
        total++; if (M_A !== 10'd0) begin bad++; $display("FAIL idle_addr got=%h exp=0", M_A); end
        total++; if (M_WEN !== 2'b10) begin bad++; $display("FAIL idle_wen got=%b exp=10", M_WEN); end
        total++; if (M_DI1 !== 32'h1111_2222 || M_DI2 !== 32'h3333_4444) begin
            bad++; $display("FAIL di_pass got=%h/%h exp=11112222/33334444", M_DI1, M_DI2); end
    endtask

    task automatic test_cpu_rw();
        next_cycle();
        C_REQ = 1'b1; C_WE = 1'b1; C_ADDR = 10'd5; C_WDATA = 32'hA5A5_0001;
        #2;
        total++; if (C_GNT !== 1'b1 || M_CSN !== 1'b1) begin
            bad++; $display("FAIL cwr_gnt got=%b/%b exp=1/1", C_GNT, M_CSN); end
        total++; if (M_WEN !== 2'b00 || M_A !== 10'd5) begin
            bad++; $display("FAIL cwr_op got=%b@%h exp=00@005", M_WEN, M_A); end
        next_cycle();
        C_WE = 1'b0; C_WDATA = 32'h0;
        #2;
        total++; if (C_GNT !== 1'b1 || M_WEN !== 2'b10) begin
            bad++; $display("FAIL crd_op got=%b/%b exp=1/10", C_GNT, M_WEN); end
        total++; if (C_RVALID !== 1'b0) begin bad++; $display("FAIL cwr_no_rvalid got=%b exp=0", C_RVALID); end
        next_cycle();
        C_REQ = 1'b0;
        #2;
        total++; if (C_RVALID !== 1'b1) begin bad++; $display("FAIL crd_rvalid got=%b exp=1", C_RVALID); end
        total++; if (C_RDATA !== 32'hA5A5_0001) begin
            bad++; $display("FAIL crd_data got=%h exp=a5a50001", C_RDATA); end
        next_cycle();
        #2;
        total++; if (C_RVALID !== 1'b0) begin bad++; $display("FAIL crd_pulse got=%b exp=0", C_RVALID); end
    endtask

    task automatic test_ip_rw();
        next_cycle();
        I_REQ = 1'b1; I_WE = 1'b1; I_ADDR = 10'd7; I_WDATA = 32'h0000_00FF;
        #2;
        total++; if (I_GNT !== 1'b1 || M_WEN !== 2'b01 || M_A !== 10'd7) begin
            bad++; $display("FAIL iwr_op got=%b/%b@%h exp=1/01@007", I_GNT, M_WEN, M_A); end
        next_cycle();
        I_WE = 1'b0; I_WDATA = 32'h0;
        #2;
        total++; if (I_GNT !== 1'b1 || M_WEN !== 2'b11) begin
            bad++; $display("FAIL ird_op got=%b/%b exp=1/11", I_GNT, M_WEN); end
        next_cycle();
        I_REQ = 1'b0;
        #2;
        total++; if (I_RVALID !== 1'b1 || C_RVALID !== 1'b0) begin
            bad++; $display("FAIL ird_rvalid got=%b/%b exp=1/0", I_RVALID, C_RVALID); end
        total++; if (I_RDATA !== 32'h0000_00FF) begin
            bad++; $display("FAIL ird_data got=%h exp=000000ff", I_RDATA); end
        next_cycle();
        #2;
        total++; if (I_RVALID !== 1'b0) begin bad++; $display("FAIL ird_pulse got=%b exp=0", I_RVALID); end
    endtask

    task automatic test_round_robin();
        logic ec;
        do_reset();
        C_WE = 1'b1; I_WE = 1'b1; C_ADDR = 10'd3; I_ADDR = 10'd9;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            C_REQ = 1'b1; I_REQ = 1'b1;
            #2;
            ec = (i % 2 == 0);
            total++; if (C_GNT !== ec || I_GNT !== !ec) begin
                bad++; $display("FAIL rr_seq%0d got=C%b/I%b exp=C%b/I%b", i, C_GNT, I_GNT, ec, !ec); end
            total++; if (M_A !== (ec ? 10'd3 : 10'd9) || M_WEN !== (ec ? 2'b00 : 2'b01)) begin
                bad++; $display("FAIL rr_mux%0d got=%h/%b", i, M_A, M_WEN); end
        end
    endtask

    task automatic test_single_and_drop();
        next_cycle();
        C_REQ = 1'b0; I_REQ = 1'b1;
        #2;
        total++; if (I_GNT !== 1'b1 || C_GNT !== 1'b0) begin
            bad++; $display("FAIL solo_ip got=C%b/I%b exp=C0/I1", C_GNT, I_GNT); end
        next_cycle();
        C_REQ = 1'b1;
        #2;
        total++; if (C_GNT !== 1'b1 || I_GNT !== 1'b0) begin
            bad++; $display("FAIL after_ip got=C%b/I%b exp=C1/I0", C_GNT, I_GNT); end
        next_cycle();
        C_REQ = 1'b0; I_REQ = 1'b0;
        #2;
        total++; if (M_CSN !== 1'b0 || C_GNT !== 1'b0 || I_GNT !== 1'b0) begin
            bad++; $display("FAIL dropped got=%b%b%b exp=000", M_CSN, C_GNT, I_GNT); end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        C_REQ = 1'b1; C_WE = 1'b0; C_ADDR = 10'd5;
        #2;
        total++; if (C_GNT !== 1'b1) begin bad++; $display("FAIL mr_gnt got=%b exp=1", C_GNT); end
        next_cycle();
        RST = 1'b1;
        #2;
        total++; if (C_RVALID !== 1'b0) begin bad++; $display("FAIL mr_rvalid got=%b exp=0", C_RVALID); end
        total++; if (C_GNT !== 1'b0 || M_CSN !== 1'b0) begin
            bad++; $display("FAIL mr_gnt_rst got=%b/%b exp=0/0", C_GNT, M_CSN); end
        next_cycle();
        RST = 1'b0; C_REQ = 1'b0;
        #2;
        total++; if (C_RVALID !== 1'b0) begin bad++; $display("FAIL mr_after got=%b exp=0", C_RVALID); end
    endtask

`ifdef DRAM_ARB_LOCK_EN
    task automatic test_lock();
        logic ec;
        do_reset();
        C_WE = 1'b1; I_WE = 1'b1;
        next_cycle();
        C_REQ = 1'b1; I_REQ = 1'b0;
        #2;
        total++; if (C_GNT !== 1'b1) begin bad++; $display("FAIL lk_pre got=%b exp=1", C_GNT); end
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            C_REQ = 1'b1; I_REQ = 1'b1; I_LOCK = 1'b1;
            #2;
            total++; if (I_GNT !== 1'b1 || C_GNT !== 1'b0) begin
                bad++; $display("FAIL lk_ip%0d got=C%b/I%b exp=C0/I1", i, C_GNT, I_GNT); end
        end
        next_cycle();
        #2;
        total++; if (C_GNT !== 1'b1 || I_GNT !== 1'b0) begin
            bad++; $display("FAIL lk_yield got=C%b/I%b exp=C1/I0", C_GNT, I_GNT); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            I_LOCK = 1'b0;
            #2;
            ec = (i % 2 == 1);
            total++; if (C_GNT !== ec || I_GNT !== !ec) begin
                bad++; $display("FAIL lk_alt%0d got=C%b/I%b exp=C%b/I%b", i, C_GNT, I_GNT, ec, !ec); end
        end
        C_REQ = 1'b0; I_REQ = 1'b0;
    endtask
`else
    task automatic test_lock();
        logic ec;
        do_reset();
        C_WE = 1'b1; I_WE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            C_REQ = 1'b1; I_REQ = 1'b1; I_LOCK = 1'b1;
            #2;
            ec = (i % 2 == 0);
            total++; if (C_GNT !== ec || I_GNT !== !ec) begin
                bad++; $display("FAIL nolock%0d got=C%b/I%b exp=C%b/I%b", i, C_GNT, I_GNT, ec, !ec); end
        end
        C_REQ = 1'b0; I_REQ = 1'b0; I_LOCK = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_rw();
        test_ip_rw();
        test_round_robin();
        test_single_and_drop();
        test_reset_mid_read();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 10, RAM address width; BW, default 32, data width; LOCK_MAX, default 16, maximum consecutive locked IP grants.
REQ-002 Clocking SHALL be one clock, CLK; reset SHALL be RST, synchronous and active-high.
REQ-003 Ports SHALL be:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- C_REQ  in  1  CPU access request
- C_WE  in  1  CPU write (1) / read (0)
- C_ADDR  in  AW  CPU address
- C_WDATA  in  BW  CPU write data
- C_GNT  out  1  CPU granted this cycle
- C_RVALID  out  1  CPU read data valid
- C_RDATA  out  BW  CPU read data
- I_REQ  in  1  IP access request
- I_WE  in  1  IP write (1) / read (0)
- I_ADDR  in  AW  IP address
- I_WDATA  in  BW  IP write data
- I_LOCK  in  1  IP burst-lock request
- I_GNT  out  1  IP granted this cycle
- I_RVALID  out  1  IP read data valid
- I_RDATA  out  BW  IP read data
- M_CSN  out  1  RAM chip select, active high
- M_A  out  AW  RAM address
- M_WEN  out  2  RAM op: 00 wr DI1, 01 wr DI2, 10 rd DOUT1, 11 rd DOUT2
- M_DI1  out  BW  RAM write data, CPU lane
- M_DI2  out  BW  RAM write data, IP lane
- M_DOUT1  in  BW  RAM read data, CPU lane
- M_DOUT2  in  BW  RAM read data, IP lane

Function
REQ-004 Grants SHALL be combinational from REQ and state, with at most one of C_GNT/I_GNT high per cycle; the RAM access completes at the next CLK edge.
REQ-005 The block SHALL assert M_CSN=1 only in a cycle with a grant, and M_CSN=0 otherwise.
REQ-006 A CPU grant SHALL drive M_A=C_ADDR and M_WEN=00 (write) or 10 (read); an IP grant SHALL drive M_A=I_ADDR and M_WEN=01 or 11.
REQ-007 M_DI1 SHALL equal C_WDATA and M_DI2 SHALL equal I_WDATA at all times.
REQ-008 When idle, the block SHALL drive M_A=0 and M_WEN=10.
REQ-009 Read response: xRVALID SHALL be a 1-cycle pulse in the cycle after a read grant; C_RDATA=M_DOUT1 and I_RDATA=M_DOUT2 SHALL be continuous; write grants SHALL produce no RVALID.
REQ-010 Arbitration SHALL be round-robin: if only one port requests, that port is granted; if both request, the port not granted most recently is granted; the last-grant pointer SHALL update on every grant.
REQ-011 The state machine SHALL have states RR (normal), LOCK (IP owns RAM) and YIELD (one forced CPU slot).
REQ-012 RR -> LOCK SHALL occur on an IP grant with I_LOCK=1.
REQ-013 In LOCK, only IP SHALL be granted, and the lock counter SHALL increment per IP grant.
REQ-014 LOCK -> RR SHALL occur when I_LOCK=0 or I_REQ=0.
REQ-015 LOCK -> YIELD SHALL occur when the counter reaches LOCK_MAX with C_REQ=1.
REQ-016 In YIELD, CPU SHALL be granted if C_REQ=1, then the block returns to RR with the counter cleared.
REQ-017 Simultaneous requests after YIELD SHALL favour IP, because the pointer then points to CPU.
REQ-018 A request deasserted before its grant SHALL be dropped; no request SHALL be queued internally.

Reset
REQ-019 While RST=1, the block SHALL hold state=RR, lock counter=0, last-grant=IP (CPU wins first contention), C_RVALID=I_RVALID=0, C_GNT=I_GNT=0 and M_CSN=0.
REQ-020 RST asserted mid-read SHALL suppress the pending RVALID.

Configuration
REQ-021 Macro DRAM_ARB_LOCK_EN: when defined, I_LOCK and the LOCK/YIELD states SHALL be implemented as above; when undefined, I_LOCK SHALL be ignored, the state SHALL remain RR permanently, and the lock counter SHALL not be synthesized.

Structure
REQ-022 A shared package SHALL hold the M_WEN op encodings (WR1, WR2, RD1, RD2) and the arbiter state enum.
REQ-023 A single sub-module, rr_pick2, SHALL implement the two-requester round-robin selection and pointer.

Verification
REQ-024 Reset then CPU write C_ADDR=5, C_WDATA=32'hA5A5_0001 -> same cycle C_GNT=1, M_CSN=1, M_WEN=00; a CPU read of addr 5 next cycle -> C_RVALID pulse one cycle later with C_RDATA=32'hA5A5_0001.
REQ-025 C_REQ and I_REQ both held high for 4 cycles after reset -> grant sequence C,I,C,I.
REQ-026 IP write addr 7, 32'h0000_00FF, then IP read addr 7 -> M_WEN=01 then 11; I_RVALID with I_RDATA=32'h0000_00FF.
REQ-027 (DRAM_ARB_LOCK_EN, LOCK_MAX=16) I_LOCK=I_REQ=C_REQ=1 continuously -> 16 IP grants, 1 CPU grant, then alternation resumes starting with IP.
REQ-028 RST asserted in the cycle after a CPU read grant -> C_RVALID stays 0; no grant in the reset cycle.
